div_seq_unsigned: RTL and testbench
===================================

DIV_SEQ_UNSIGNED -- requirements
Module: div_seq_unsigned

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The port clk SHALL be an input, 1 bit wide, and act as the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide; it is the reset, synchronous and active-high.
REQ-004 The port start SHALL be an input, 1 bit wide; a high level requests a division of the currently presented operands.
REQ-005 The port dividend SHALL be an input, 16 bits wide, carrying the unsigned dividend.
REQ-006 The port divisor SHALL be an input, 8 bits wide, carrying the unsigned divisor.
REQ-007 The port busy SHALL be an output, 1 bit wide, high while an iteration is in progress.
REQ-008 The port done SHALL be an output, 1 bit wide, carrying a one-cycle completion pulse.
REQ-009 The port quotient SHALL be an output, 16 bits wide, carrying the unsigned quotient.
REQ-010 The port remainder SHALL be an output, 8 bits wide, carrying the unsigned remainder.
REQ-011 The port div_by_zero SHALL be an output, 1 bit wide, present only when DIV_ZERO_FLAG_EN is defined.

Function
REQ-012 The block SHALL compute quotient = dividend / divisor and remainder = dividend mod divisor, unsigned, using restoring division, one quotient bit per cycle, MSB first.
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE; transitions: IDLE -> RUN on start, RUN -> DONE after 16 iteration cycles, DONE -> IDLE, or DONE -> RUN if start is high in DONE.
REQ-014 The block SHALL accept start only in IDLE or DONE; dividend and divisor SHALL be latched on the accepting edge, and later input changes SHALL have no effect.
REQ-015 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-016 busy SHALL be high for exactly 16 cycles, the cycles after the accepting edge.
REQ-017 done SHALL be high for exactly one cycle, the 17th cycle after the accepting edge, with busy low in that cycle.
REQ-018 The partial remainder register SHALL be 9 bits wide so that the subtract and compare never overflows.
REQ-019 quotient and remainder SHALL update only on entry to DONE and SHALL hold their values until the next entry to DONE.
REQ-020 For divisor = 0, the result SHALL be quotient = 16'hFFFF and remainder = dividend[7:0].
REQ-021 A back-to-back start in DONE SHALL begin a new operation with no idle cycle; done for the new operation SHALL follow 17 cycles later.

Reset
REQ-022 rst high at any clock edge SHALL force the FSM to IDLE, even mid-operation, abandoning the operation without a done pulse.
REQ-023 During and after reset, busy, done, quotient, remainder and div_by_zero (if present) SHALL all be 0.
REQ-024 start SHALL be ignored in a cycle where rst is high.

Configuration
REQ-025 With the macro DIV_ZERO_FLAG_EN defined:
- the div_by_zero port SHALL exist;
- a start with divisor = 0 SHALL go directly IDLE/DONE -> DONE, with done on the next cycle, busy never asserted, and the REQ-020 results;
- div_by_zero SHALL be high together with done and hold with the results.
REQ-026 Without DIV_ZERO_FLAG_EN, the div_by_zero port SHALL be absent, and divisor = 0 SHALL run the full 16 cycles, still producing the REQ-020 results.

Verification
REQ-027 The bench SHALL drive dividend = 1000, divisor = 7 -> done on the 17th cycle with quotient = 142, remainder = 6.
REQ-028 The bench SHALL drive dividend = 65535, divisor = 255 -> quotient = 257, remainder = 0; and dividend = 5, divisor = 9 -> quotient = 0, remainder = 5.
REQ-029 The bench SHALL drive dividend = 16'h1234, divisor = 0 -> quotient = 16'hFFFF, remainder = 8'h34; with the macro, done after 1 cycle with div_by_zero = 1; without it, done after 17 cycles.
REQ-030 The bench SHALL drive start held high continuously with operands 100/3, then 200/9 -> done pulses 17 cycles apart with results 33 r1, then 22 r2; operand changes while busy ignored.
REQ-031 The bench SHALL assert rst on cycle 8 of an operation on 40000/13 -> no done pulse, all outputs 0, a subsequent start on 40000/13 yields 3076 r12.

Source files
------------

// File: rtl/div_seq_unsigned.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional macro DIV_ZERO_FLAG_EN adds div_by_zero and a single-cycle divide-by-zero path.
module div_seq_unsigned (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic        busy,
   output logic        done,
   output logic [15:0] quotient,
   output logic [7:0]  remainder
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic        div_by_zero
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_quo;
   logic [8:0]  r_rem;
   logic [7:0]  r_dvs;
   logic [3:0]  r_cnt;

   logic        w_accept;
   logic        w_zero_fast;
   logic        w_last;
   logic [9:0]  w_trial;
   logic        w_ge;
   logic [8:0]  w_rem_nxt;
   logic [15:0] w_quo_nxt;

   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_state == RUN) && (r_cnt == 4'd15);

`ifdef DIV_ZERO_FLAG_EN
   assign w_zero_fast = w_accept && (divisor == 8'd0);
`else
   assign w_zero_fast = 1'b0;
`endif

   // Shift the next dividend bit into the partial remainder, then trial-subtract.
   // For a zero divisor every trial succeeds, leaving all-ones and dividend[7:0].
   assign w_trial   = {r_rem, r_quo[15]};
   assign w_ge      = (w_trial >= {2'b00, r_dvs});
   assign w_rem_nxt = w_ge ? (w_trial[8:0] - {1'b0, r_dvs}) : w_trial[8:0];
   assign w_quo_nxt = {r_quo[14:0], w_ge};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = w_zero_fast ? DONE : RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (w_accept) begin
               w_next = w_zero_fast ? DONE : RUN;
            end else begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Working registers carry no reset; they are always reloaded on acceptance.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_quo <= dividend;
         r_rem <= 9'd0;
         r_dvs <= divisor;
         r_cnt <= 4'd0;
      end else if (r_state == RUN) begin
         r_quo <= w_quo_nxt;
         r_rem <= w_rem_nxt;
         r_cnt <= r_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= 16'd0;
         remainder <= 8'd0;
`ifdef DIV_ZERO_FLAG_EN
         div_by_zero <= 1'b0;
`endif
      end else if (w_last) begin
         quotient  <= w_quo_nxt;
         remainder <= w_rem_nxt[7:0];
`ifdef DIV_ZERO_FLAG_EN
         div_by_zero <= 1'b0;
`endif
      end else if (w_zero_fast) begin
         quotient  <= 16'hFFFF;
         remainder <= dividend[7:0];
`ifdef DIV_ZERO_FLAG_EN
         div_by_zero <= 1'b1;
`endif
      end
   end

   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);

endmodule

// File: tb/tb_div_seq_unsigned.sv
// Self-checking bench for div_seq_unsigned: timeline reference model checked every cycle,
// directed literal cases, then randomized start/operand/reset traffic.
module tb_div_seq_unsigned;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] dividend = 16'd0;
   logic [7:0]  divisor = 8'd0;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [7:0]  remainder;
`ifdef DIV_ZERO_FLAG_EN
   logic        div_by_zero;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   div_seq_unsigned dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef DIV_ZERO_FLAG_EN
      ,
      .div_by_zero (div_by_zero)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: m_ph is the position of the coming cycle relative to the
   // accepting edge (0 = idle, 1..16 = busy, 17 = done cycle).
   int          m_ph = 0;
   bit          m_seen_rst = 1'b0;
   logic [15:0] e_q = 16'd0;
   logic [7:0]  e_r = 8'd0;
   logic [15:0] p_q = 16'd0;
   logic [7:0]  p_r = 8'd0;
   logic [15:0] t_mod;
`ifdef DIV_ZERO_FLAG_EN
   logic        e_z = 1'b0;
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_ph = 0;
         e_q = 16'd0;
         e_r = 8'd0;
`ifdef DIV_ZERO_FLAG_EN
         e_z = 1'b0;
`endif
         m_seen_rst = 1'b1;
      end else if (start && (m_ph == 0 || m_ph == 17)) begin
         if (divisor == 8'd0) begin
            p_q = 16'hFFFF;
            p_r = dividend[7:0];
         end else begin
            p_q = dividend / {8'd0, divisor};
            t_mod = dividend % {8'd0, divisor};
            p_r = t_mod[7:0];
         end
`ifdef DIV_ZERO_FLAG_EN
         if (divisor == 8'd0) begin
            e_q = p_q;
            e_r = p_r;
            e_z = 1'b1;
            m_ph = 17;
         end else begin
            m_ph = 1;
         end
`else
         m_ph = 1;
`endif
      end else if (m_ph >= 1 && m_ph <= 15) begin
         m_ph++;
      end else if (m_ph == 16) begin
         m_ph = 17;
         e_q = p_q;
         e_r = p_r;
`ifdef DIV_ZERO_FLAG_EN
         e_z = 1'b0;
`endif
      end else if (m_ph == 17) begin
         m_ph = 0;
      end
   end

   always @(negedge clk) begin
      if (m_seen_rst) begin
         chk("busy", {31'd0, busy}, {31'd0, (m_ph >= 1 && m_ph <= 16)});
         chk("done", {31'd0, done}, {31'd0, (m_ph == 17)});
         chk("quotient", {16'd0, quotient}, {16'd0, e_q});
         chk("remainder", {24'd0, remainder}, {24'd0, e_r});
`ifdef DIV_ZERO_FLAG_EN
         chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e_z});
`endif
      end
   end

   task automatic wait_done(output int lat, output bit found);
      lat = 0;
      found = 1'b0;
      while (!found && lat < 40) begin
         @(negedge clk);
         lat++;
         if (done === 1'b1) found = 1'b1;
      end
   endtask

   task automatic check_result(input string tag, input int lat, input bit found, input int exp_lat,
                               input logic [15:0] eq, input logic [7:0] er);
      chk({tag, "_done_seen"}, {31'd0, found}, 32'd1);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
      chk({tag, "_remainder"}, {24'd0, remainder}, {24'd0, er});
   endtask

   task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                         input int exp_lat, input logic [15:0] eq, input logic [7:0] er);
      int lat;
      bit found;
      @(posedge clk); #2;
      dividend = a;
      divisor = b;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      dividend = 16'($urandom);
      divisor = 8'($urandom);
      wait_done(lat, found);
      check_result(tag, lat, found, exp_lat, eq, er);
   endtask

   initial begin
      int lat;
      bit found;
      int dones;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_quotient", {16'd0, quotient}, 32'd0);
      chk("rst_remainder", {24'd0, remainder}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;

      run_op("d1000_7", 16'd1000, 8'd7, 17, 16'd142, 8'd6);
      run_op("d65535_255", 16'd65535, 8'd255, 17, 16'd257, 8'd0);
      run_op("d5_9", 16'd5, 8'd9, 17, 16'd0, 8'd5);
`ifdef DIV_ZERO_FLAG_EN
      run_op("dzero", 16'h1234, 8'd0, 1, 16'hFFFF, 8'h34);
      chk("dzero_flag", {31'd0, div_by_zero}, 32'd1);
      run_op("after_zero", 16'd1000, 8'd7, 17, 16'd142, 8'd6);
      chk("after_zero_flag", {31'd0, div_by_zero}, 32'd0);
`else
      run_op("dzero", 16'h1234, 8'd0, 17, 16'hFFFF, 8'h34);
`endif

      // Start held high across two operations; operands change while busy.
      @(posedge clk); #2;
      dividend = 16'd100;
      divisor = 8'd3;
      start = 1'b1;
      @(posedge clk); #2;
      dividend = 16'd200;
      divisor = 8'd9;
      wait_done(lat, found);
      check_result("b2b_first", lat, found, 17, 16'd33, 8'd1);
      @(posedge clk); #2;
      start = 1'b0;
      dividend = 16'd7777;
      divisor = 8'd1;
      wait_done(lat, found);
      check_result("b2b_second", lat, found, 17, 16'd22, 8'd2);

      // Reset during cycle 8 of an operation, with start also high under reset.
      @(posedge clk); #2;
      dividend = 16'd40000;
      divisor = 8'd13;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b1;
      start = 1'b1;
      dividend = 16'd9;
      divisor = 8'd2;
      @(posedge clk); #2;
      rst = 1'b0;
      start = 1'b0;
      dones = 0;
      repeat (25) begin
         @(negedge clk);
         if (done !== 1'b0) dones++;
      end
      chk("rst_mid_no_done", dones, 0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_quotient", {16'd0, quotient}, 32'd0);
      chk("rst_mid_remainder", {24'd0, remainder}, 32'd0);
      run_op("rst_retry", 16'd40000, 8'd13, 17, 16'd3076, 8'd12);

      // Random traffic: starts at any time, occasional zero divisors and resets.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         start = ($urandom_range(0, 3) == 0);
         dividend = 16'($urandom);
         divisor = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
         rst = ($urandom_range(0, 299) == 0);
      end
      @(posedge clk); #2;
      rst = 1'b0;
      start = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
